// File: rtl/wb_burst_master.sv
// Wishbone B3 burst initiator for SDRAM bring-up / BIST.
// Writes an incrementing pattern as one burst, reads it back as a second
// burst, and reports pass, mismatch count and watchdog timeout.
module wb_burst_master #(
    parameter int APP_AW  = 26,
    parameter int SDR_DW  = 32,
    parameter int SDR_BW  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [APP_AW-1:0] base_addr,
    input  logic [7:0]        burst_len,
    input  logic [SDR_DW-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [SDR_DW-1:0] wb_dat_o,
    output logic [SDR_BW-1:0] wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [SDR_DW-1:0] wb_dat_i
);

    // state | meaning
    // IDLE  | waiting for start
    // WR    | write burst, one beat per ack
    // GAP   | single idle bus cycle between bursts
    // RD    | read burst, compare each returned beat
    // FIN   | done pulse, results frozen until next start
    typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_FIN} state_t;

    // Watchdog is a down-counter; reaching zero with stb still unacked aborts,
    // so stb is held for at most TIMEOUT cycles.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LOAD   = WD_W'(TIMEOUT - 1);
    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(SDR_BW);
    localparam logic [2:0]        CTI_INCR  = 3'b010;
    localparam logic [2:0]        CTI_EOB   = 3'b111;

    state_t              state_q, state_d;
    logic [APP_AW-1:0]   base_q, base_d, addr_q, addr_d;
    logic [SDR_DW-1:0]   seed_q, seed_d, dat_q, dat_d;
    logic [7:0]          len_q, len_d, beat_q, beat_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [15:0]         err_q, err_d, err_nx;
    logic                pass_q, pass_d, tmo_q, tmo_d, busy_q, busy_d, done_q, done_d;
    logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [SDR_BW-1:0]   sel_q, sel_d;
    logic [2:0]          cti_q, cti_d;

    logic                ack_beat, wd_expire, last_beat, rd_miss;

    function automatic logic [2:0] cti_for(input logic [7:0] idx, input logic [7:0] n);
        return (idx == n - 8'd1) ? CTI_EOB : CTI_INCR;
    endfunction

    assign ack_beat  = stb_q & wb_ack_i;
    assign wd_expire = stb_q & ~wb_ack_i & (wdog_q == '0);
    assign last_beat = (beat_q == len_q - 8'd1);
    assign rd_miss   = (wb_dat_i != seed_q + SDR_DW'(beat_q));
    assign err_nx    = (rd_miss && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

    // State register
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (burst_len != 8'd0) ? S_WR : S_FIN;
            S_WR: begin
                if (wd_expire)                  state_d = S_FIN;
                else if (ack_beat && last_beat) state_d = S_GAP;
            end
            S_GAP: state_d = S_RD;
            S_RD: begin
                if (wd_expire)                  state_d = S_FIN;
                else if (ack_beat && last_beat) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and beat datapath
    always_comb begin
        base_d = base_q;  seed_d = seed_q;  len_d = len_q;
        addr_d = addr_q;  dat_d  = dat_q;   beat_d = beat_q;
        err_d  = err_q;   pass_d = pass_q;  tmo_d  = tmo_q;
        busy_d = busy_q;  done_d = 1'b0;
        cyc_d  = cyc_q;   stb_d  = stb_q;   we_d   = we_q;
        sel_d  = sel_q;   cti_d  = cti_q;
        wdog_d = (stb_q && !wb_ack_i && wdog_q != '0) ? wdog_q - WD_W'(1) : wdog_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base_addr;  len_d = burst_len;  seed_d = seed;
                    err_d  = '0;  pass_d = 1'b0;  tmo_d = 1'b0;
                    beat_d = '0;  wdog_d = WD_LOAD;
                    if (burst_len != 8'd0) begin
                        busy_d = 1'b1;
                        cyc_d  = 1'b1;  stb_d = 1'b1;  we_d = 1'b1;
                        sel_d  = {SDR_BW{1'b1}};
                        addr_d = base_addr;
                        dat_d  = seed;
                        cti_d  = cti_for(8'd0, burst_len);
                    end else begin
                        done_d = 1'b1;
                        pass_d = 1'b1;
                    end
                end
            end
            S_WR, S_RD: begin
                if (wd_expire) begin
                    cyc_d = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;
                    sel_d = '0;    cti_d = '0;
                    busy_d = 1'b0; done_d = 1'b1;
                    tmo_d  = 1'b1; pass_d = 1'b0;
                end else if (ack_beat) begin
                    wdog_d = WD_LOAD;
                    if (state_q == S_RD) err_d = err_nx;
                    if (last_beat) begin
                        cyc_d  = 1'b0;  stb_d = 1'b0;  we_d = 1'b0;
                        cti_d  = '0;    beat_d = '0;
                        if (state_q == S_RD) begin
                            sel_d  = '0;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            pass_d = (err_nx == 16'd0) && !tmo_q;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = addr_q + ADDR_STEP;
                        cti_d  = cti_for(beat_q + 8'd1, len_q);
                        if (state_q == S_WR) dat_d = dat_q + SDR_DW'(1);
                    end
                end
            end
            S_GAP: begin
                cyc_d  = 1'b1;  stb_d = 1'b1;  we_d = 1'b0;
                addr_d = base_q;
                cti_d  = cti_for(8'd0, len_q);
                wdog_d = WD_LOAD;
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            base_q <= '0;  seed_q <= '0;  len_q <= '0;
            addr_q <= '0;  dat_q  <= '0;  beat_q <= '0;  wdog_q <= '0;
            err_q  <= '0;  pass_q <= 1'b0;  tmo_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;
            cyc_q  <= 1'b0;  stb_q  <= 1'b0;  we_q <= 1'b0;
            sel_q  <= '0;    cti_q  <= '0;
        end else begin
            base_q <= base_d;  seed_q <= seed_d;  len_q <= len_d;
            addr_q <= addr_d;  dat_q  <= dat_d;   beat_q <= beat_d;  wdog_q <= wdog_d;
            err_q  <= err_d;   pass_q <= pass_d;  tmo_q <= tmo_d;
            busy_q <= busy_d;  done_q <= done_d;
            cyc_q  <= cyc_d;   stb_q  <= stb_d;   we_q <= we_d;
            sel_q  <= sel_d;   cti_q  <= cti_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = tmo_q;
    assign err_cnt   = err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_cti_o  = cti_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master with a Wishbone slave memory model.
module tb_wb_burst_master;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          sys_clk = 1'b0;
    logic          resetn  = 1'b0;
    logic          start   = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    burst_len = '0;
    logic [DW-1:0] seed      = '0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_cnt;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [BW-1:0] wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic          wb_ack_i = 1'b0;
    logic [DW-1:0] wb_dat_i = '0;

    wb_burst_master #(.APP_AW(AW), .SDR_DW(DW), .SDR_BW(BW), .TIMEOUT(15)) dut (
        .sys_clk(sys_clk), .resetn(resetn), .start(start),
        .base_addr(base_addr), .burst_len(burst_len), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic [2:0]    cti;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mem[logic [AW-1:0]];

    // modes: 0 clean, 1 random stalls + start while busy, 2 corrupt read beat 2,
    //        3 reads return zero, 4 slave never acks
    int cur_mode   = 0;
    int n_vec      = 0;
    int n_err      = 0;
    int wr_acks    = 0;
    int rd_idx     = 0;
    int done_cnt   = 0;
    int gap_cycles = 0;
    int stb_cycles = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: decides ack on the falling edge, checks each accepted beat
    initial begin
        int    wait_cnt;
        beat_t e;
        logic [DW-1:0] d;
        wait_cnt = 0;
        forever begin
            @(negedge sys_clk);
            wb_ack_i = 1'b0;
            if (resetn) begin
                if (done) done_cnt++;
                if (busy && !wb_stb_o && !done) gap_cycles++;
                if (wb_stb_o) stb_cycles++;
                if (wb_stb_o && cur_mode != 4) begin
                    if (wait_cnt > 0) begin
                        wait_cnt--;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (exp_q.size() == 0) begin
                            chk("extra_beat", 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("we",   wb_we_o,   e.we);
                            chk("addr", wb_addr_o, e.addr);
                            chk("cti",  wb_cti_o,  e.cti);
                            chk("sel",  wb_sel_o,  4'hF);
                            chk("cyc",  wb_cyc_o,  1'b1);
                            if (e.we) begin
                                chk("wdat", wb_dat_o, e.dat);
                                mem[wb_addr_o] = wb_dat_o;
                                wr_acks++;
                            end else begin
                                d = mem.exists(wb_addr_o) ? mem[wb_addr_o] : '0;
                                if (cur_mode == 3) d = '0;
                                if (cur_mode == 2 && rd_idx == 2) d = d ^ 32'h1;
                                wb_dat_i = d;
                                rd_idx++;
                            end
                        end
                        wait_cnt = (cur_mode == 1) ? int'($urandom_range(0, 2)) : 0;
                    end
                end
            end
        end
    end

    task automatic run(input logic [AW-1:0] b, input logic [7:0] n,
                       input logic [DW-1:0] sd, input int mode);
        beat_t e;
        int    exp_err;
        int    lat;
        logic  exp_pass;
        cur_mode = mode;
        wr_acks = 0; rd_idx = 0; done_cnt = 0; gap_cycles = 0; stb_cycles = 0;
        exp_q.delete();
        exp_err = 0;
        if (mode != 4) begin
            for (int ph = 0; ph < 2; ph++) begin
                for (int i = 0; i < int'(n); i++) begin
                    e.we   = (ph == 0);
                    e.addr = b + AW'(i * BW);
                    e.dat  = sd + DW'(i);
                    e.cti  = (i == int'(n) - 1) ? 3'b111 : 3'b010;
                    exp_q.push_back(e);
                    if (ph == 1 && mode == 3 && (sd + DW'(i)) != '0) exp_err++;
                end
            end
            if (mode == 2 && n > 8'd2) exp_err = 1;
        end
        exp_pass = (exp_err == 0) && (mode != 4);

        @(posedge sys_clk); #1;
        start = 1'b1; base_addr = b; burst_len = n; seed = sd;
        @(posedge sys_clk); #1;
        start = 1'b0;
        if (mode == 1) begin
            repeat (3) @(posedge sys_clk);
            #1 start = 1'b1; burst_len = 8'd0; base_addr = '0;
            @(posedge sys_clk); #1 start = 1'b0;
        end

        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            chk("done_seen", 64'd0, 64'd1);
        end else begin
            chk("err_cnt", err_cnt, exp_err);
            chk("pass",    pass,    exp_pass);
            chk("timeout", timeout, (mode == 4));
            chk("busy_fin", busy,   1'b0);
            chk("stb_fin", wb_stb_o, 1'b0);
            if (n == 8'd0) chk("len0_latency", lat, 0);
        end
        repeat (3) @(negedge sys_clk);
        chk("done_pulses", done_cnt, 1);
        chk("pass_hold",   pass,     exp_pass);
        chk("beats_left",  exp_q.size(), 0);
        chk("gap_cycles",  gap_cycles, (n != 8'd0 && mode != 4) ? 1 : 0);
        if (mode == 4) chk("stb_cycles", stb_cycles, 15);
        if (n == 8'd0) chk("len0_stb", stb_cycles, 0);
    endtask

    initial begin
        int   k;
        logic hit;
        #1;
        chk("rst_ctrl", {busy, done, pass, timeout, err_cnt, wb_cyc_o, wb_stb_o,
                         wb_we_o, wb_sel_o, wb_cti_o}, 64'd0);
        chk("rst_addr", wb_addr_o, 64'd0);
        chk("rst_dat",  wb_dat_o,  64'd0);
        #22 resetn = 1'b1;

        run(26'h0000100, 8'd4, 32'h12345678, 0);
        run(26'h3FFFFFC, 8'd2, 32'hCAFEF00D, 0);
        run(26'h0002000, 8'd8, 32'hFFFFFFFE, 1);
        run(26'h0000400, 8'd8, 32'hA5A50000, 2);
        run(26'h0000800, 8'd8, 32'h00000010, 3);
        run(26'h0000C00, 8'd4, 32'h11111111, 4);
        run(26'h0001000, 8'd0, 32'h22222222, 0);
        run(26'h0001100, 8'd1, 32'h33333333, 0);

        // Reset during write beat 3 of an 8-beat run
        cur_mode = 0; wr_acks = 0; done_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            beat_t e;
            e.we = 1'b1; e.addr = 26'h0005000 + AW'(i * BW); e.dat = 32'h0BAD0000 + DW'(i);
            e.cti = (i == 7) ? 3'b111 : 3'b010;
            exp_q.push_back(e);
        end
        @(posedge sys_clk); #1;
        start = 1'b1; base_addr = 26'h0005000; burst_len = 8'd8; seed = 32'h0BAD0000;
        @(posedge sys_clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (wr_acks == 3) begin
                hit = 1'b1;
                break;
            end
            @(posedge sys_clk); #1;
        end
        chk("rst_reached_beat3", hit, 1'b1);
        chk("rst_pre_stb", wb_stb_o, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, pass, timeout, err_cnt, wb_cyc_o, wb_stb_o,
                             wb_we_o, wb_sel_o, wb_cti_o}, 64'd0);
        chk("rst_mid_addr", wb_addr_o, 64'd0);
        chk("rst_mid_dat",  wb_dat_o,  64'd0);
        repeat (3) @(negedge sys_clk);
        #2 resetn = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("rst_no_done", done_cnt, 0);
        exp_q.delete();

        run(26'h0006000, 8'd2, 32'h5A5A5A5A, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

endmodule
